// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 link: state encoding, default
// sync word and seed, LFSR geometry and the 8-step byte generator.
package prbs_pkg;

   localparam int unsigned LFSR_W = 15;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned TAP_A  = 14;
   localparam int unsigned TAP_B  = 13;

   localparam logic [31:0]       DEF_PATTERN = 32'hAABBCCDD;
   localparam logic [LFSR_W-1:0] DEF_SEED    = 15'h7FFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
   } state_e;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic [LFSR_W-1:0] state;
   } prbs_step_t;

   // Eight LFSR steps; the first generated bit lands in data[7].
   function automatic prbs_step_t prbs_step8(input logic [LFSR_W-1:0] s);
      prbs_step_t r;
      logic       nb;
      r.state = s;
      r.data  = '0;
      for (int unsigned i = 0; i < BYTE_W; i++) begin
         nb      = r.state[TAP_A] ^ r.state[TAP_B];
         r.state = {r.state[LFSR_W-2:0], nb};
         r.data  = {r.data[BYTE_W-2:0], nb};
      end
      return r;
   endfunction

endpackage

// File: rtl/pattern_prbs_tx_if.sv
// Valid/ready byte stream between the pattern transmitter and the serializer.
interface pattern_prbs_tx_if;
   import prbs_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [BYTE_W-1:0] out_byte;

   modport master (output out_valid, output out_byte, input out_ready);
   modport slave  (input out_valid, input out_byte, output out_ready);

endinterface

// File: rtl/prbs_lfsr.sv
// PRBS-15 generator: 15-bit state with load/advance and a combinational
// next-byte output; reused by the receive-side checker.
module prbs_lfsr
   import prbs_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              adv,
   output logic [BYTE_W-1:0] byte_c
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] src_c;
   prbs_step_t        step_c;

   // load+adv in the same cycle produces the first byte straight from SEED.
   always_comb begin
      src_c  = load ? SEED : lfsr_q;
      step_c = prbs_step8(src_c);
      byte_c = step_c.data;
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = step_c.state;
      end else if (load) begin
         lfsr_d = SEED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/pattern_prbs_tx.sv
// Sync-pattern + PRBS-15 payload byte transmitter.
// Optional payload bit-0 error injection under `PRBS_TX_ERR_INJ_EN.
module pattern_prbs_tx
   import prbs_pkg::*;
#(
   parameter logic [31:0]       PATTERN = DEF_PATTERN,
   parameter int unsigned       PAY_LEN = 16,
   parameter logic [LFSR_W-1:0] SEED    = DEF_SEED
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              start,
   input  logic [CNT_W-1:0]  n,
`ifdef PRBS_TX_ERR_INJ_EN
   input  logic              err_inj,
`endif
   pattern_prbs_tx_if.master out_if,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0]       S_IDLE   = ST_IDLE;
   localparam logic [1:0]       S_HDR    = ST_HDR;
   localparam logic [1:0]       S_PAY    = ST_PAY;
   localparam bit               HAS_PAY  = (PAY_LEN != 0);
   localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_LEN - 1);

   logic [1:0]        state_q,     state_d;
   logic [CNT_W-1:0]  n_q,         n_d;
   logic [1:0]        idx_q,       idx_d;
   logic [CNT_W-1:0]  rep_q,       rep_d;
   logic [CNT_W-1:0]  pay_cnt_q,   pay_cnt_d;
   logic              out_valid_q, out_valid_d;
   logic [BYTE_W-1:0] out_byte_q,  out_byte_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
`ifdef PRBS_TX_ERR_INJ_EN
   logic              inj_arm_q,   inj_arm_d;
`endif

   logic              xfer_c;
   logic              lfsr_load_c;
   logic              lfsr_adv_c;
   logic              pay_stage_c;
   logic [BYTE_W-1:0] lfsr_byte_c;

   function automatic logic [BYTE_W-1:0] pat_byte(input logic [1:0] idx);
      logic [BYTE_W-1:0] b;
      case (idx)
         2'd0:    b = PATTERN[31:24];
         2'd1:    b = PATTERN[23:16];
         2'd2:    b = PATTERN[15:8];
         default: b = PATTERN[7:0];
      endcase
      return b;
   endfunction

   prbs_lfsr #(.SEED(SEED)) u_lfsr (
      .clk    (CLK),
      .rst_n  (RSTn),
      .load   (lfsr_load_c),
      .adv    (lfsr_adv_c),
      .byte_c (lfsr_byte_c)
   );

   // Next-state and output staging; a new byte is staged only on a transfer.
   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      idx_d       = idx_q;
      rep_d       = rep_q;
      pay_cnt_d   = pay_cnt_q;
      out_valid_d = out_valid_q;
      out_byte_d  = out_byte_q;
      done_d      = 1'b0;
      lfsr_load_c = 1'b0;
      lfsr_adv_c  = 1'b0;
      pay_stage_c = 1'b0;
      xfer_c      = out_valid_q & out_if.out_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d         = n;
               lfsr_load_c = 1'b1;
               idx_d       = '0;
               rep_d       = '0;
               pay_cnt_d   = '0;
               if (n != '0) begin
                  state_d     = S_HDR;
                  out_valid_d = 1'b1;
                  out_byte_d  = pat_byte(2'd0);
               end else if (HAS_PAY) begin
                  state_d     = S_PAY;
                  out_valid_d = 1'b1;
                  lfsr_adv_c  = 1'b1;
                  pay_stage_c = 1'b1;
                  out_byte_d  = lfsr_byte_c;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         S_HDR: begin
            if (xfer_c) begin
               if (idx_q == 2'd3) begin
                  idx_d = '0;
                  rep_d = rep_q + CNT_W'(1);
                  if (rep_q == n_q - CNT_W'(1)) begin
                     if (HAS_PAY) begin
                        state_d     = S_PAY;
                        lfsr_adv_c  = 1'b1;
                        pay_stage_c = 1'b1;
                        out_byte_d  = lfsr_byte_c;
                     end else begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                     end
                  end else begin
                     out_byte_d = pat_byte(2'd0);
                  end
               end else begin
                  idx_d      = 2'(idx_q + 2'd1);
                  out_byte_d = pat_byte(2'(idx_q + 2'd1));
               end
            end
         end

         S_PAY: begin
            if (xfer_c) begin
               pay_cnt_d = pay_cnt_q + CNT_W'(1);
               if (pay_cnt_q == PAY_LAST) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  lfsr_adv_c  = 1'b1;
                  pay_stage_c = 1'b1;
                  out_byte_d  = lfsr_byte_c;
               end
            end
         end

         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
         end
      endcase

`ifdef PRBS_TX_ERR_INJ_EN
      // The armed flag is consumed when the next payload byte is staged,
      // which is exactly the next payload byte to be transferred.
      inj_arm_d = (inj_arm_q | err_inj) & ~pay_stage_c;
      if (pay_stage_c && (inj_arm_q || err_inj)) begin
         out_byte_d[0] = ~out_byte_d[0];
      end
`endif

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         idx_q       <= '0;
         rep_q       <= '0;
         pay_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PRBS_TX_ERR_INJ_EN
         inj_arm_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         rep_q       <= rep_d;
         pay_cnt_q   <= pay_cnt_d;
         out_valid_q <= out_valid_d;
         out_byte_q  <= out_byte_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef PRBS_TX_ERR_INJ_EN
         inj_arm_q   <= inj_arm_d;
`endif
      end
   end

   assign out_if.out_valid = out_valid_q;
   assign out_if.out_byte  = out_byte_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_pattern_prbs_tx.sv
// Self-checking bench for pattern_prbs_tx: byte scoreboard fed from a
// bit-serial PRBS model, plus a PAY_LEN=0 instance for header-only frames.
module tb_pattern_prbs_tx;

   logic       CLK = 1'b0;
   logic       RSTn;
   logic       start;
   logic       start0;
   logic [7:0] n;
   logic       done;
   logic       busy;
   logic       done0;
   logic       busy0;
`ifdef PRBS_TX_ERR_INJ_EN
   logic       err_inj;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_q[$];
   logic [31:0] pat      = 32'hAABBCCDD;
   logic [3:0]  rdy_pat  = 4'b1001;
   int          cyc_n    = 0;
   int          last_xfer_cyc = -10;
   int          valid_cyc = 0;
   bit          done_seen = 0;
   bit          stall_prev = 0;
   logic [7:0]  stall_byte = '0;

   pattern_prbs_tx_if out_if ();
   pattern_prbs_tx_if out_if0 ();

   assign out_if0.out_ready = 1'b1;

   pattern_prbs_tx #(.PAY_LEN(16)) dut (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .start   (start),
      .n       (n),
`ifdef PRBS_TX_ERR_INJ_EN
      .err_inj (err_inj),
`endif
      .out_if  (out_if),
      .busy    (busy),
      .done    (done)
   );

   pattern_prbs_tx #(.PAY_LEN(0)) dut0 (
      .CLK     (CLK),
      .RSTn    (RSTn),
      .start   (start0),
      .n       (n),
`ifdef PRBS_TX_ERR_INJ_EN
      .err_inj (1'b0),
`endif
      .out_if  (out_if0),
      .busy    (busy0),
      .done    (done0)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected bytes of one frame: reps sync words then 16 PRBS bytes.
   task automatic push_frame(input int reps, input bit inj);
      logic [14:0] l;
      logic [7:0]  b;
      logic        nb;
      for (int r = 0; r < reps; r++)
         for (int i = 0; i < 4; i++)
            exp_q.push_back(pat[8*(3-i) +: 8]);
      l = 15'h7FFF;
      for (int k = 0; k < 16; k++) begin
         b = '0;
         for (int j = 0; j < 8; j++) begin
            nb = l[14] ^ l[13];
            l  = {l[13:0], nb};
            b  = {b[6:0], nb};
         end
         if (inj && k == 0) b[0] = ~b[0];
         exp_q.push_back(b);
      end
   endtask

   // Observe at the falling edge: what will transfer at the next rising edge.
   task automatic monitor();
      logic [7:0] e;
      cyc_n++;
      if (stall_prev) begin
         chk("stall_valid_hold", 32'(out_if.out_valid), 32'd1);
         chk("stall_byte_hold", 32'(out_if.out_byte), 32'(stall_byte));
      end
      if (out_if.out_valid) valid_cyc++;
      if (out_if.out_valid && out_if.out_ready) begin
         last_xfer_cyc = cyc_n;
         if (exp_q.size() == 0) begin
            chk("unexpected_byte", 32'(out_if.out_byte), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("byte", 32'(out_if.out_byte), 32'(e));
         end
      end
      stall_prev = out_if.out_valid && !out_if.out_ready;
      stall_byte = out_if.out_byte;
      if (done) begin
         done_seen = 1;
         chk("done_after_last_xfer", 32'(cyc_n), 32'(last_xfer_cyc + 1));
         chk("valid_low_at_done", 32'(out_if.out_valid), 32'd0);
         chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      monitor();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_until_done(input bit toggle);
      done_seen = 0;
      for (int i = 0; i < 300 && !done_seen; i++) begin
         if (toggle) out_if.out_ready = rdy_pat[i % 4];
         tick();
      end
      chk("done_within_budget", 32'(done_seen), 32'd1);
      out_if.out_ready = 1'b1;
   endtask

   initial begin
      RSTn             = 1'b0;
      start            = 1'b0;
      start0           = 1'b0;
      n                = 8'd0;
      out_if.out_ready = 1'b1;
`ifdef PRBS_TX_ERR_INJ_EN
      err_inj          = 1'b0;
`endif
      #12;
      chk("rst_valid", 32'(out_if.out_valid), 32'd0);
      chk("rst_byte", 32'(out_if.out_byte), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(posedge CLK); #1;
      RSTn = 1'b1;
      tick();
      chk("idle_valid", 32'(out_if.out_valid), 32'd0);

      // Frame A: n=2, full-rate; n changed mid-frame must not matter.
      n = 8'd2;
      start = 1'b1;
      push_frame(2, 0);
      valid_cyc = 0;
      tick();
      start = 1'b0;
      n = 8'd5;
      chk("a_first_valid", 32'(out_if.out_valid), 32'd1);
      chk("a_first_byte", 32'(out_if.out_byte), 32'hAA);
      chk("a_busy", 32'(busy), 32'd1);
      run_until_done(0);
      chk("a_valid_cycles", 32'(valid_cyc), 32'd24);
      chk("a_busy_after", 32'(busy), 32'd0);

      // Frame B: same frame under a 1,0,0,1 ready pattern.
      n = 8'd2;
      start = 1'b1;
      push_frame(2, 0);
      tick();
      start = 1'b0;
      run_until_done(1);

      // Frame C: n=0 goes straight to payload.
      n = 8'd0;
      start = 1'b1;
      push_frame(0, 0);
      tick();
      start = 1'b0;
      chk("c_first_byte", 32'(out_if.out_byte), 32'h00);
      chk("c_first_valid", 32'(out_if.out_valid), 32'd1);
      run_until_done(0);

      // PAY_LEN=0 instance: n=0 gives only a done pulse, n=1 one sync word.
      n = 8'd0;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("z_done", 32'(done0), 32'd1);
      chk("z_no_valid", 32'(out_if0.out_valid), 32'd0);
      tick();
      chk("z_done_single", 32'(done0), 32'd0);
      n = 8'd1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("z_hdr_byte", 32'(out_if0.out_byte), 32'(pat[8*(3-i) +: 8]));
         chk("z_hdr_busy", 32'(busy0), 32'd1);
         tick();
      end
      chk("z_hdr_done", 32'(done0), 32'd1);
      chk("z_hdr_valid_low", 32'(out_if0.out_valid), 32'd0);

      // Back-to-back: start held across a frame and its done cycle.
      n = 8'd1;
      start = 1'b1;
      push_frame(1, 0);
      tick();
      run_until_done(0);
      start = 1'b0;
      push_frame(1, 0);
      chk("b2b_restart_valid", 32'(out_if.out_valid), 32'd1);
      chk("b2b_restart_byte", 32'(out_if.out_byte), 32'hAA);
      chk("b2b_busy", 32'(busy), 32'd1);
      run_until_done(0);

      // Reset during the third header byte aborts with no done pulse.
      n = 8'd2;
      start = 1'b1;
      push_frame(2, 0);
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("abort_third_byte", 32'(out_if.out_byte), 32'hCC);
      done_seen = 0;
      RSTn = 1'b0;
      #1;
      chk("abort_valid", 32'(out_if.out_valid), 32'd0);
      chk("abort_byte", 32'(out_if.out_byte), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      tick();
      tick();
      RSTn = 1'b1;
      tick();
      chk("abort_no_done", 32'(done_seen), 32'd0);
      n = 8'd1;
      start = 1'b1;
      push_frame(1, 0);
      tick();
      start = 1'b0;
      chk("post_abort_byte", 32'(out_if.out_byte), 32'hAA);
      run_until_done(0);

`ifdef PRBS_TX_ERR_INJ_EN
      // Error injection armed during HDR hits only the first payload byte.
      n = 8'd1;
      start = 1'b1;
      push_frame(1, 1);
      tick();
      start = 1'b0;
      err_inj = 1'b1;
      tick();
      err_inj = 1'b0;
      run_until_done(0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
